// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the 16-bit processor.
// Sequences each instruction through fetch/decode/exec/mem/writeback with a
// memory ready handshake, detects illegal opcodes and memory timeouts (sticky
// fault), and counts retired instructions.
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned FUNCT_W     = 4,
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  function_code,
  input  logic                mem_ready,
  input  logic                zero,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                Branch,
  output logic                Jump,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                RegWriteSource,
  output logic                ALUSource,
  output logic                fault,
  output logic                retired,
  output logic [CNT_W-1:0]    retire_count
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_W-1:0] OpR    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OpLw   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OpSw   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OpAddi = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OpBeq  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OpBne  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OpJmp  = OPCODE_W'(6);

  localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(1);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StJump,
    StFault
  } state_e;

  state_e              state_q, state_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [OPCODE_W-1:0] op_q;
  logic [FUNCT_W-1:0]  funct_q;
  logic [CNT_W-1:0]    cnt_q;

  logic mem_wait;
  logic timeout;
  logic illegal;
  logic retired_raw;

  // Stalled on memory: only fetch and mem states issue requests.
  assign mem_wait = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
  // This stalled cycle is the MEM_TIMEOUT-th consecutive one.
  assign timeout  = mem_wait && (wait_q >= WaitW'(MEM_TIMEOUT - 1));
  assign illegal  = (opcode > OpJmp) ||
                    ((opcode == OpR) && (function_code > FUNCT_W'(3)));

  // State, wait counter, latched instruction fields and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      wait_q  <= '0;
      op_q    <= '0;
      funct_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == StDecode) begin
        op_q    <= opcode;
        funct_q <= function_code;
      end
      if (retired_raw) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StFault;
        end
      end
      StDecode: begin
        if (illegal) begin
          state_d = StFault;
        end else if (opcode == OpJmp) begin
          state_d = StJump;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if ((op_q == OpLw) || (op_q == OpSw)) begin
          state_d = StMem;
        end else if ((op_q == OpR) || (op_q == OpAddi)) begin
          state_d = StWb;
        end else begin
          state_d = StFetch;
        end
      end
      StMem: begin
        if (mem_ready) begin
          state_d = (op_q == OpLw) ? StWb : StFetch;
        end else if (timeout) begin
          state_d = StFault;
        end
      end
      StWb:    state_d = StFetch;
      StJump:  state_d = StFetch;
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
    // Count only while stalled in the same state; any transition clears it.
    if (mem_wait && (state_d == state_q)) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  // Output decode from registered state and latched fields; all zero in reset.
  always_comb begin
    PCWrite        = 1'b0;
    IRWrite        = 1'b0;
    RegDst         = 1'b0;
    RegWrite       = 1'b0;
    Branch         = 1'b0;
    Jump           = 1'b0;
    ALUop          = AluAdd;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    RegWriteSource = 1'b0;
    ALUSource      = 1'b0;
    fault          = 1'b0;
    retired_raw    = 1'b0;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUop   = AluAdd;
        end
      end
      StExec: begin
        if (op_q == OpR) begin
          ALUop     = ALUOP_W'(funct_q);
          ALUSource = 1'b0;
        end else if ((op_q == OpLw) || (op_q == OpSw) || (op_q == OpAddi)) begin
          ALUop     = AluAdd;
          ALUSource = 1'b1;
        end else if ((op_q == OpBeq) || (op_q == OpBne)) begin
          ALUop       = AluSub;
          Branch      = 1'b1;
          PCWrite     = (op_q == OpBeq) ? zero : ~zero;
          retired_raw = 1'b1;
        end
      end
      StMem: begin
        MemRead  = (op_q == OpLw);
        MemWrite = (op_q == OpSw);
        if (mem_ready && (op_q == OpSw)) begin
          retired_raw = 1'b1;
        end
      end
      StWb: begin
        RegWrite       = 1'b1;
        RegDst         = (op_q == OpR);
        RegWriteSource = (op_q == OpLw);
        retired_raw    = 1'b1;
      end
      StJump: begin
        Jump        = 1'b1;
        PCWrite     = 1'b1;
        retired_raw = 1'b1;
      end
      StFault: begin
        fault = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      PCWrite        = 1'b0;
      IRWrite        = 1'b0;
      RegDst         = 1'b0;
      RegWrite       = 1'b0;
      Branch         = 1'b0;
      Jump           = 1'b0;
      ALUop          = '0;
      MemRead        = 1'b0;
      MemWrite       = 1'b0;
      RegWriteSource = 1'b0;
      ALUSource      = 1'b0;
      fault          = 1'b0;
      retired_raw    = 1'b0;
    end
  end

  assign retired      = retired_raw;
  assign retire_count = cnt_q;

endmodule
